instr_fetch_buffer: RTL and testbench

- Consumer stage placed directly downstream of the instruction ROM transmitter.
- Drives the transmitter's sync request, which is a one-cycle registered request/ack source with a fixed wrap depth. Captures each returned instruction word into a small FIFO.
- Presents the FIFO head to the core decode stage with a valid/ready handshake.
- Tags every word with its byte PC, derived from the source word index.

---
 rtl/instr_fetch_buffer_if.sv | 31 +++
 rtl/instr_fetch_buffer.sv | 189 ++++++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_buffer_if.sv
// Handshake bundle for instr_fetch_buffer: fetch control, source request/ack,
// and the valid/ready head presented to decode.
// slave is the fetch buffer's view; master is the surrounding environment's view.
interface instr_fetch_buffer_if #(
    parameter int IWIDTH = 32,
    parameter int FDEPTH = 4
);
    localparam int CW = $clog2(FDEPTH + 1);

    logic              f_i_en;
    logic              f_i_flush;
    logic              f_o_syn;
    logic [IWIDTH-1:0] f_i_instr;
    logic              f_i_ack;
    logic [IWIDTH-1:0] f_o_instr;
    logic [31:0]       f_o_pc;
    logic              f_o_valid;
    logic              f_i_ready;
    logic [CW-1:0]     f_o_count;
    logic              f_o_err;

    modport slave (
        input  f_i_en, f_i_flush, f_i_instr, f_i_ack, f_i_ready,
        output f_o_syn, f_o_instr, f_o_pc, f_o_valid, f_o_count, f_o_err
    );

    modport master (
        output f_i_en, f_i_flush, f_i_instr, f_i_ack, f_i_ready,
        input  f_o_syn, f_o_instr, f_o_pc, f_o_valid, f_o_count, f_o_err
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: requests words from the instruction ROM source,
// tags each returned word with its byte PC and queues it for decode.
// Optional ack watchdog: define FETCH_ACK_TIMEOUT_EN to enable it.
module instr_fetch_buffer #(
    parameter int IWIDTH    = 32,
    parameter int FDEPTH    = 4,
    parameter int SRC_DEPTH = 36,
    parameter int TIMEOUT   = 16
) (
    input logic                 f_clk,
    input logic                 f_rst,
    instr_fetch_buffer_if.slave bus
);
    localparam int CW = $clog2(FDEPTH + 1);
    localparam int PW = $clog2(FDEPTH);
    localparam int XW = (SRC_DEPTH > 1) ? $clog2(SRC_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Reject parameter sets the pointer arithmetic cannot support.
    if (FDEPTH < 2 || (FDEPTH & (FDEPTH - 1)) != 0 || SRC_DEPTH < 1 || TIMEOUT < 1) begin : g_param_check
        $error("instr_fetch_buffer: illegal parameter set");
    end

    state_t            r_state, w_state_next;
    logic [1:0]        r_inflight, w_inflight_next;
    logic [XW-1:0]     r_idx, w_idx_next;
    logic              r_syn, w_syn_next;
    logic [CW-1:0]     r_count, w_count_next;
    logic [PW-1:0]     r_rd_ptr, r_wr_ptr, w_rd_next, w_wr_next;
    logic [IWIDTH-1:0] r_head_instr, w_head_instr_next;
    logic [XW-1:0]     r_head_idx, w_head_idx_next;
    logic [IWIDTH-1:0] r_mem_instr [FDEPTH];
    logic [XW-1:0]     r_mem_idx   [FDEPTH];
    logic              w_pop, w_take, w_timeout, w_err_next;

`ifdef FETCH_ACK_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic           r_err;
    logic [WDW-1:0] r_wd, w_wd_next;
`endif

    // Next-state computation for the whole fetch pipeline.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        w_pop  = (r_count != '0) && bus.f_i_ready && !bus.f_i_flush;
        // A returned word is kept only outside DRAIN, without flush, and when a slot exists.
        w_take = bus.f_i_ack && !bus.f_i_flush && (r_state != DRAIN)
                 && ((r_count != CW'(FDEPTH)) || w_pop);

        // Outstanding requests: +1 per accepted request, -1 per ack, clamped to the 2-bit range.
        w_inflight_next = r_inflight;
        if (r_syn && !bus.f_i_ack && r_inflight != 2'd3)
            w_inflight_next = r_inflight + 2'd1;
        else if (!r_syn && bus.f_i_ack && r_inflight != 2'd0)
            w_inflight_next = r_inflight - 2'd1;

`ifdef FETCH_ACK_TIMEOUT_EN
        w_wd_next = '0;
        w_timeout = 1'b0;
        if (!bus.f_i_flush && r_inflight != 2'd0 && !bus.f_i_ack) begin
            if (r_wd == WDW'(TIMEOUT - 1))
                w_timeout = 1'b1;
            else
                w_wd_next = r_wd + WDW'(1);
        end
        w_err_next = !bus.f_i_flush && (r_err || w_timeout);
        if (w_timeout)
            w_inflight_next = 2'd0;
`else
        w_timeout  = 1'b0;
        w_err_next = 1'b0;
`endif

        // Occupancy and pointers; flush empties the queue outright.
        w_count_next = r_count;
        w_rd_next    = r_rd_ptr;
        w_wr_next    = r_wr_ptr;
        if (bus.f_i_flush) begin
            w_count_next = '0;
            w_rd_next    = '0;
            w_wr_next    = '0;
        end else begin
            if (w_take) w_wr_next = r_wr_ptr + PW'(1);
            if (w_pop)  w_rd_next = r_rd_ptr + PW'(1);
            if (w_take && !w_pop)
                w_count_next = r_count + CW'(1);
            else if (!w_take && w_pop)
                w_count_next = r_count - CW'(1);
        end

        // Every ack consumes one source word, kept or not, so the PC tracks the source.
        w_idx_next = r_idx;
        if (bus.f_i_ack)
            w_idx_next = (r_idx == XW'(SRC_DEPTH - 1)) ? '0 : r_idx + XW'(1);

        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.f_i_en && !bus.f_i_flush) w_state_next = RUN;
            RUN:     if (!bus.f_i_en && w_inflight_next == 2'd0) w_state_next = IDLE;
            DRAIN:   if (w_inflight_next == 2'd0) w_state_next = bus.f_i_en ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
        if (bus.f_i_flush && w_inflight_next != 2'd0)
            w_state_next = DRAIN;
        if (w_timeout)
            w_state_next = IDLE;

        // Request only when every outstanding word is guaranteed a slot.
        w_syn_next = (w_state_next == RUN) && bus.f_i_en && !bus.f_i_flush && !w_err_next
                     && ((int'(w_count_next) + int'(w_inflight_next)) < FDEPTH);

        // Head register follows the new read slot; bypass when that slot is written now.
        w_head_instr_next = r_head_instr;
        w_head_idx_next   = r_head_idx;
        if (w_count_next != '0) begin
            if (w_take && (r_wr_ptr == w_rd_next)) begin
                w_head_instr_next = bus.f_i_instr;
                w_head_idx_next   = r_idx;
            end else begin
                w_head_instr_next = r_mem_instr[w_rd_next];
                w_head_idx_next   = r_mem_idx[w_rd_next];
            end
        end
    end

    // Control state, occupancy, source index and registered outputs.
    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            r_state      <= IDLE;
            r_inflight   <= 2'd0;
            r_idx        <= '0;
            r_syn        <= 1'b0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_head_instr <= '0;
            r_head_idx   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state      <= w_state_next;
            r_inflight   <= w_inflight_next;
            r_idx        <= w_idx_next;
            r_syn        <= w_syn_next;
            r_count      <= w_count_next;
            r_rd_ptr     <= w_rd_next;
            r_wr_ptr     <= w_wr_next;
            r_head_instr <= w_head_instr_next;
            r_head_idx   <= w_head_idx_next;
        end
    end

    // Queue storage, written only for kept words.
    always_ff @(posedge f_clk) begin
        // NOTE: storage has no reset; an entry is read only after it has been written.
        if (w_take) begin
            r_mem_instr[r_wr_ptr] <= bus.f_i_instr;
            r_mem_idx[r_wr_ptr]   <= r_idx;
        end
    end

`ifdef FETCH_ACK_TIMEOUT_EN
    // Ack watchdog counter and sticky error flag.
    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_wd  <= w_wd_next;
            r_err <= w_err_next;
        end
    end

    assign bus.f_o_err = r_err;
`else
    assign bus.f_o_err = 1'b0;
`endif

    assign bus.f_o_syn   = r_syn;
    assign bus.f_o_valid = (r_count != '0);
    assign bus.f_o_count = r_count;
    assign bus.f_o_instr = r_head_instr;
    assign bus.f_o_pc    = 32'({r_head_idx, 2'b00});

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: ROM source model, directed
// vector table, hand-written corner sequences and a randomized run checked
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_instr_fetch_buffer;
    localparam int IWIDTH    = 32;
    localparam int FDEPTH    = 4;
    localparam int SRC_DEPTH = 36;
    localparam int TIMEOUT   = 16;

    logic f_clk = 1'b0;
    logic f_rst = 1'b0;
    always #5 f_clk = ~f_clk;

    instr_fetch_buffer_if #(.IWIDTH(IWIDTH), .FDEPTH(FDEPTH)) bus ();

    instr_fetch_buffer #(
        .IWIDTH(IWIDTH), .FDEPTH(FDEPTH), .SRC_DEPTH(SRC_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .f_clk(f_clk),
        .f_rst(f_rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom(input int k);
        return 32'h13 + 32'(k);
    endfunction

    // ---------------- source ROM model ----------------
    int src_idx  = 0;
    bit src_hold = 1'b0;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    mstate_t m_state;
    entry_t  m_q[$];
    int      m_inflight;
    int      m_idx;
    bit      m_syn;

    task automatic model_reset();
        m_state    = M_IDLE;
        m_q.delete();
        m_inflight = 0;
        m_idx      = 0;
        m_syn      = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit fl, input bit rdy, input bit ack,
                              input logic [31:0] ins);
        int      infl;
        bit      popd;
        mstate_t nxt;
        entry_t  e;
        infl = m_inflight + (m_syn ? 1 : 0) - (ack ? 1 : 0);
        if (infl < 0) infl = 0;
        if (infl > 3) infl = 3;
        popd = (m_q.size() != 0) && rdy;
        if (fl) begin
            m_q.delete();
        end else begin
            if (popd) void'(m_q.pop_front());
            if (ack && m_state != M_DRAIN && m_q.size() < FDEPTH) begin
                e.instr = ins;
                e.pc    = 32'(m_idx * 4);
                m_q.push_back(e);
            end
        end
        if (ack) m_idx = (m_idx + 1) % SRC_DEPTH;
        nxt = m_state;
        case (m_state)
            M_IDLE:  if (en && !fl) nxt = M_RUN;
            M_RUN:   if (!en && infl == 0) nxt = M_IDLE;
            M_DRAIN: if (infl == 0) nxt = en ? M_RUN : M_IDLE;
            default: nxt = M_IDLE;
        endcase
        if (fl && infl != 0) nxt = M_DRAIN;
        m_syn      = (nxt == M_RUN) && en && !fl && ((m_q.size() + infl) < FDEPTH);
        m_state    = nxt;
        m_inflight = infl;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_syn"},   bus.f_o_syn,   m_syn);
        check({tag, "_valid"}, bus.f_o_valid, m_q.size() != 0);
        check({tag, "_count"}, bus.f_o_count, m_q.size());
        if (m_q.size() != 0) begin
            check({tag, "_instr"}, bus.f_o_instr, m_q[0].instr);
            check({tag, "_pc"},    bus.f_o_pc,    m_q[0].pc);
        end
        check({tag, "_err"}, bus.f_o_err, 1'b0);
    endtask

    // One clock: sample inputs, advance model, then play the source's registered response.
    task automatic tick();
        bit          en, fl, rdy, ack, dsyn;
        logic [31:0] ins;
        en   = bus.f_i_en;
        fl   = bus.f_i_flush;
        rdy  = bus.f_i_ready;
        ack  = bus.f_i_ack;
        ins  = bus.f_i_instr;
        dsyn = bus.f_o_syn;
        @(posedge f_clk);
        model_step(en, fl, rdy, ack, ins);
        #1;
        if (src_hold) begin
            bus.f_i_ack   = 1'b0;
            bus.f_i_instr = $urandom;
        end else begin
            bus.f_i_ack = dsyn;
            if (dsyn) begin
                bus.f_i_instr = rom(src_idx);
                src_idx       = (src_idx + 1) % SRC_DEPTH;
            end else begin
                bus.f_i_instr = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        bus.f_i_en    = 1'b0;
        bus.f_i_flush = 1'b0;
        bus.f_i_ready = 1'b0;
        bus.f_i_ack   = 1'b0;
        bus.f_i_instr = '0;
        src_idx       = 0;
        src_hold      = 1'b0;
        f_rst         = 1'b0;
        #1;
        model_reset();
        check("rst_syn",   bus.f_o_syn,   1'b0);
        check("rst_valid", bus.f_o_valid, 1'b0);
        check("rst_count", bus.f_o_count, 0);
        check("rst_instr", bus.f_o_instr, 0);
        check("rst_pc",    bus.f_o_pc,    0);
        check("rst_err",   bus.f_o_err,   1'b0);
        repeat (2) @(posedge f_clk);
        @(negedge f_clk);
        f_rst = 1'b1;
    endtask

    typedef struct {
        bit          en;
        bit          ready;
        bit          flush;
        bit          syn;
        bit          valid;
        int          count;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [31:0] prev_pc;
        bit          saw_wrap;
        bit          got;
        logic [31:0] exp_pc[4];
        logic [31:0] exp_in[4];

        // Startup, back-pressure to full and resume, from reset.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'h00};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h04};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2, 32'h04};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 32'h04};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 32'h04};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 32'h04};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'h08};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 32'h0C};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 32'h10};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            bus.f_i_en    = tbl[i].en;
            bus.f_i_ready = tbl[i].ready;
            bus.f_i_flush = tbl[i].flush;
            tick();
            check($sformatf("vec%0d_syn", i),   bus.f_o_syn,   tbl[i].syn);
            check($sformatf("vec%0d_valid", i), bus.f_o_valid, tbl[i].valid);
            check($sformatf("vec%0d_count", i), bus.f_o_count, tbl[i].count);
            if (tbl[i].valid) begin
                check($sformatf("vec%0d_pc", i),    bus.f_o_pc,    tbl[i].pc);
                check($sformatf("vec%0d_instr", i), bus.f_o_instr, rom(int'(tbl[i].pc >> 2)));
            end
        end

        // Wrap of the source index: pc 0x8C is followed by pc 0x00 and ROM word 0.
        do_reset();
        bus.f_i_en    = 1'b1;
        bus.f_i_ready = 1'b1;
        saw_wrap      = 1'b0;
        prev_pc       = '1;
        for (int i = 0; i < 90; i++) begin
            tick();
            check_model("wrap");
            if (bus.f_o_valid) begin
                if (prev_pc == 32'h8C && bus.f_o_pc == 32'h0) begin
                    saw_wrap = 1'b1;
                    check("wrap_instr", bus.f_o_instr, 32'h13);
                end
                prev_pc = bus.f_o_pc;
            end
        end
        check("wrap_seen", saw_wrap, 1'b1);

        // Flush with three words queued and one word in flight.
        do_reset();
        bus.f_i_en    = 1'b1;
        bus.f_i_ready = 1'b1;
        repeat (4) tick();
        bus.f_i_ready = 1'b0;
        repeat (2) tick();
        check("fl_pre_count", bus.f_o_count, 3);
        check("fl_pre_ack",   bus.f_i_ack,   1'b1);
        bus.f_i_flush = 1'b1;
        tick();
        bus.f_i_flush = 1'b0;
        check("fl_valid", bus.f_o_valid, 1'b0);
        check("fl_count", bus.f_o_count, 0);
        check("fl_syn",   bus.f_o_syn,   1'b0);
        bus.f_i_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            check_model("flr");
            got = bus.f_o_valid;
        end
        check("fl_resume", got, 1'b1);
        check("fl_next_pc",    bus.f_o_pc,    32'h14);
        check("fl_next_instr", bus.f_o_instr, 32'h18);

        // Full queue: ack without pop is dropped; ack with pop keeps count at 4 and order.
        do_reset();
        bus.f_i_en    = 1'b1;
        bus.f_i_ready = 1'b1;
        repeat (4) tick();
        bus.f_i_ready = 1'b0;
        repeat (4) tick();
        check("full_count", bus.f_o_count, 4);
        bus.f_i_en    = 1'b0;
        bus.f_i_ack   = 1'b1;
        bus.f_i_instr = 32'hA5A5_0000;
        tick();
        check_model("drop");
        check("drop_count", bus.f_o_count, 4);
        check("drop_pc",    bus.f_o_pc,    32'h04);
        bus.f_i_ack   = 1'b1;
        bus.f_i_instr = 32'hA5A5_0001;
        bus.f_i_ready = 1'b1;
        tick();
        check_model("pp");
        check("pp_count", bus.f_o_count, 4);
        exp_pc = '{32'h08, 32'h0C, 32'h10, 32'h18};
        exp_in = '{32'h15, 32'h16, 32'h17, 32'hA5A5_0001};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_order%0d_pc", i),    bus.f_o_pc,    exp_pc[i]);
            check($sformatf("pp_order%0d_instr", i), bus.f_o_instr, exp_in[i]);
            tick();
            check_model("ppd");
        end
        check("pp_empty", bus.f_o_valid, 1'b0);

        // Randomized traffic against the reference model, with a reset mid-fetch.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int i = 0; i < 700; i++) begin
                bus.f_i_en    = ($urandom % 8) != 0;
                bus.f_i_ready = ($urandom % 3) != 0;
                bus.f_i_flush = ($urandom % 20) == 0;
                tick();
                check_model("rnd");
            end
        end
        bus.f_i_flush = 1'b0;

`ifdef FETCH_ACK_TIMEOUT_EN
        // Source silent with requests outstanding: watchdog trips after TIMEOUT cycles.
        do_reset();
        src_hold      = 1'b1;
        bus.f_i_en    = 1'b1;
        bus.f_i_ready = 1'b1;
        repeat (17) tick();
        check("wd_not_yet", bus.f_o_err, 1'b0);
        tick();
        check("wd_err", bus.f_o_err, 1'b1);
        check("wd_syn", bus.f_o_syn, 1'b0);
        tick();
        check("wd_sticky",     bus.f_o_err, 1'b1);
        check("wd_sticky_syn", bus.f_o_syn, 1'b0);
        bus.f_i_flush = 1'b1;
        tick();
        bus.f_i_flush = 1'b0;
        check("wd_clear", bus.f_o_err, 1'b0);
        src_hold = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound on the run.
    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
